// File: rtl/fixed_point_mac_if.sv
// Operand/result handshake bundle for fixed_point_mac.
// master = producer of beats and consumer of results; slave = the MAC.
interface fixed_point_mac_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             inLast;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output inValid, data0, data1, inLast, outReady,
    input  inReady, outValid, result, overflow
  );

  modport slave (
    input  inValid, data0, data1, inLast, outReady,
    output inReady, outValid, result, overflow
  );
endinterface

// File: rtl/fixed_point_mac.sv
// Pipelined signed fixed-point multiply-accumulate with per-burst rescaling.
// Define FIXED_POINT_MAC_SATURATE_EN to clamp overflowing results instead of wrapping.
module fixed_point_mac #(
  parameter int WIDTH     = 32,
  parameter int FRAC_SIZE = 30,
  parameter int GUARD     = 8,
  parameter int ROUND     = 1
) (
  input logic              clk,
  input logic              rstN,
  fixed_point_mac_if.slave bus
);
  localparam int PW  = 2 * WIDTH;
  localparam int ACC = PW + GUARD;

  localparam logic [ACC-1:0] RND_ADD =
    (ROUND != 0) ? ({{(ACC-1){1'b0}}, 1'b1} << (FRAC_SIZE - 1)) : '0;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    advance;
  logic signed [PW-1:0]    a_ext, b_ext, prod;
  logic                    s1_valid, s1_last;
  logic signed [PW-1:0]    s1_prod;
  logic signed [ACC-1:0]   acc, sum, rounded, t;
  logic                    first;
  logic [ACC-WIDTH:0]      t_hi;
  logic                    fmt_ovf;
  logic [WIDTH-1:0]        fmt_res;
  logic                    out_valid, out_ovf;
  logic [WIDTH-1:0]        out_res;

  assign advance      = !out_valid || bus.outReady;
  assign bus.inReady  = advance;
  assign bus.outValid = out_valid;
  assign bus.result   = out_res;
  assign bus.overflow = out_ovf;

  assign a_ext = {{WIDTH{bus.data0[WIDTH-1]}}, bus.data0};
  assign b_ext = {{WIDTH{bus.data1[WIDTH-1]}}, bus.data1};
  assign prod  = a_ext * b_ext;

  always_comb begin
    sum     = (first ? '0 : acc) + {{GUARD{s1_prod[PW-1]}}, s1_prod};
    rounded = sum + RND_ADD;
    t       = rounded >>> FRAC_SIZE;
    // T fits in WIDTH bits only when every bit above the result sign bit matches it
    t_hi    = t[ACC-1:WIDTH-1];
    fmt_ovf = !((&t_hi) || !(|t_hi));
`ifdef FIXED_POINT_MAC_SATURATE_EN
    fmt_res = fmt_ovf ? (t[ACC-1] ? SAT_MIN : SAT_MAX) : t[WIDTH-1:0];
`else
    fmt_res = t[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (advance) begin
      s1_valid <= bus.inValid;
      if (bus.inValid) begin
        s1_prod <= prod;
        s1_last <= bus.inLast;
      end
    end
  end

  // outValid may only drop while advance is high, i.e. the held result was taken
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        if (s1_last) begin
          out_res <= fmt_res;
          out_ovf <= fmt_ovf;
          acc     <= '0;
          first   <= 1'b1;
        end else begin
          acc   <= sum;
          first <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_mac.sv
// Directed bench for fixed_point_mac at WIDTH=8, FRAC_SIZE=6 (1.0 = 64).
// Two instances share all stimulus: one truncating, one rounding.
module tb_fixed_point_mac;
  logic       clk = 1'b0;
  logic       rstN;
  logic       in_valid, in_last, out_ready;
  logic [7:0] d0, d1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stream_drops = 0;
  logic streaming = 1'b0;

  logic [8:0] q0[$], q1[$];
  int         t0[$];

  fixed_point_mac_if #(.WIDTH(8)) r0 ();
  fixed_point_mac_if #(.WIDTH(8)) r1 ();

  assign r0.inValid  = in_valid;
  assign r0.data0    = d0;
  assign r0.data1    = d1;
  assign r0.inLast   = in_last;
  assign r0.outReady = out_ready;
  assign r1.inValid  = in_valid;
  assign r1.data0    = d0;
  assign r1.data1    = d1;
  assign r1.inLast   = in_last;
  assign r1.outReady = out_ready;

  fixed_point_mac #(.WIDTH(8), .FRAC_SIZE(6), .GUARD(8), .ROUND(0)) dut_r0 (
    .clk(clk), .rstN(rstN), .bus(r0)
  );
  fixed_point_mac #(.WIDTH(8), .FRAC_SIZE(6), .GUARD(8), .ROUND(1)) dut_r1 (
    .clk(clk), .rstN(rstN), .bus(r1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are sampled on the falling edge; inputs only change 2 units after a rising edge.
  always @(negedge clk) begin
    if (rstN) begin
      if (r0.outValid && out_ready) begin
        q0.push_back({r0.overflow, r0.result});
        t0.push_back(cyc);
      end
      if (r1.outValid && out_ready) q1.push_back({r1.overflow, r1.result});
      if (streaming && !r0.inReady) stream_drops = stream_drops + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    d0 = a;
    d1 = b;
    in_last = last;
    @(negedge clk);
    while (!r0.inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_n(input string tag, input int n);
    for (int i = 0; i < 100 && (q0.size() < n || q1.size() < n); i++) @(negedge clk);
    check({tag, "_cnt0"}, 32'(q0.size()), 32'(n));
    check({tag, "_cnt1"}, 32'(q1.size()), 32'(n));
    @(posedge clk);
    #2;
  endtask

  task automatic pop_check(input string tag, input logic [8:0] e0, input logic [8:0] e1);
    logic [8:0] g0, g1;
    g0 = (q0.size() > 0) ? q0.pop_front() : 9'h1FF;
    g1 = (q1.size() > 0) ? q1.pop_front() : 9'h1FF;
    check({tag, "_trunc"}, 32'(g0), 32'(e0));
    check({tag, "_round"}, 32'(g1), 32'(e1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [8:0] ovf_exp;
    logic [7:0] ks[6];
    ks = '{8'd5, 8'hFD, 8'd7, 8'd12, 8'd1, 8'hF8};
`ifdef FIXED_POINT_MAC_SATURATE_EN
    ovf_exp = 9'h17F;
`else
    ovf_exp = 9'h1C0;
`endif
    rstN = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    d0 = '0;
    d1 = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_r0", {r0.outValid, r0.overflow, r0.result}, 32'd0);
    check("rst_r1", {r1.outValid, r1.overflow, r1.result}, 32'd0);
    @(posedge clk);
    #2 rstN = 1'b1;
    @(negedge clk);
    check("rst_inready", 32'(r0.inReady), 32'd1);
    @(posedge clk);
    #2;

    // 0.5 * 0.5 with latency check
    beat(8'd32, 8'd32, 1'b1);
    @(negedge clk);
    check("lat_c1", 32'(r0.outValid), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(r0.outValid), 32'd1);
    @(posedge clk);
    #2;
    wait_n("single", 1);
    pop_check("single", 9'd16, 9'd16);

    // rounding: +0.5 LSB and -0.5 LSB
    beat(8'd1, 8'd32, 1'b1);
    beat(8'hFF, 8'd32, 1'b1);
    wait_n("rnd", 2);
    pop_check("rnd_pos", 9'h000, 9'h001);
    pop_check("rnd_neg", 9'h0FF, 9'h000);

    // 1.0 + 1.0 + 1.0 overflows the Q2.6 range
    beat(8'd64, 8'd64, 1'b0);
    beat(8'd64, 8'd64, 1'b0);
    beat(8'd64, 8'd64, 1'b1);
    wait_n("ovf", 1);
    pop_check("ovf", ovf_exp, ovf_exp);

    // backpressure: two beats fit, third stalls until the consumer is ready
    out_ready = 1'b0;
    beat(8'd16, 8'd64, 1'b1);
    beat(8'd32, 8'd64, 1'b1);
    fork
      beat(8'd48, 8'd64, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check("bp_inready", 32'(r0.inReady), 32'd0);
        check("bp_hold_v", 32'(r0.outValid), 32'd1);
        check("bp_hold_r0", 32'(r0.result), 32'd16);
        check("bp_hold_r1", 32'(r1.result), 32'd16);
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    wait_n("bp", 3);
    pop_check("bp_0", 9'd16, 9'd16);
    pop_check("bp_1", 9'd32, 9'd32);
    pop_check("bp_2", 9'd48, 9'd48);

    // streaming: one beat and one result per cycle
    t0.delete();
    streaming = 1'b1;
    for (int i = 0; i < 6; i++) beat(ks[i], 8'd64, 1'b1);
    streaming = 1'b0;
    wait_n("stream", 6);
    check("stream_drops", 32'(stream_drops), 32'd0);
    check("stream_span", 32'((t0.size() == 6) ? (t0[5] - t0[0]) : -1), 32'd5);
    for (int i = 0; i < 6; i++) pop_check("stream", {1'b0, ks[i]}, {1'b0, ks[i]});

    // reset in the middle of a burst discards the partial sum
    beat(8'd64, 8'd64, 1'b0);
    beat(8'd64, 8'd64, 1'b0);
    rstN = 1'b0;
    @(negedge clk);
    check("midrst_r0", {r0.outValid, r0.overflow, r0.result}, 32'd0);
    check("midrst_r1", {r1.outValid, r1.overflow, r1.result}, 32'd0);
    @(posedge clk);
    #2 rstN = 1'b1;
    beat(8'd32, 8'd32, 1'b1);
    wait_n("midrst", 1);
    pop_check("midrst", 9'd16, 9'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
